ahb3lite_to_apb_bridge: RTL and testbench
=========================================

Name: ahb3lite_to_apb_bridge

Overview:
Single-clock AHB3-lite slave to APB4 master bridge. It converts each AHB NONSEQ/SEQ transfer addressed to it into exactly one APB SETUP/ACCESS transaction. It inserts AHB wait states until the APB transaction completes and maps PSLVERR to a two-cycle AHB ERROR response. It sits between the AHB interconnect (HSEL from the decoder) and the APB peripheral segment, and uses the team's ahb3lite_pkg encodings.

Parameters:
HADDR_SIZE, 32, AHB address width
PADDR_SIZE, 16, APB address width; PADDR = captured HADDR[PADDR_SIZE-1:0]
DATA_SIZE, 32, AHB and APB data width; only 32 is supported

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  synchronous active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  HADDR_SIZE  AHB address
HWDATA  in  DATA_SIZE  AHB write data (data phase)
HRDATA  out  DATA_SIZE  AHB read data
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HBURST  in  3  burst type (ignored; each beat is handled independently)
HPROT  in  4  protection
HTRANS  in  2  transfer type
HMASTLOCK  in  1  ignored
HREADY  in  1  bus-level ready
HREADYOUT  out  1  slave ready
HRESP  out  1  OKAY=0 / ERROR=1
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PPROT  out  3  APB protection
PWRITE  out  1  APB direction
PSTRB  out  4  APB write strobes
PADDR  out  PADDR_SIZE  APB address
PWDATA  out  DATA_SIZE  APB write data
PRDATA  in  DATA_SIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset values (HRESET sampled high at an edge): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PSTRB=0, PPROT=0, PADDR=0, PWDATA=0. A reset mid-transaction aborts it: PSEL and PENABLE are 0 from the next edge, with no completion.
- Accept condition (cycle N): HSEL & HREADY & HTRANS is NONSEQ or SEQ, and state is IDLE. On accept, register HADDR, HWRITE, HSIZE and HPROT.
- IDLE/BUSY HTRANS, HSEL=0, or HREADY=0: no capture, and HREADYOUT stays 1 with HRESP=OKAY.
- Illegal transfer: HSIZE > HSIZE_WORD, or misaligned (halfword with HADDR[0]=1; word with HADDR[1:0]≠0). The bridge generates no APB cycle and goes directly to ERR1 at N+1.
- State machine for a legal transfer:
  - IDLE -> LOAD (N+1): HREADYOUT=0; latch HWDATA into PWDATA at end of cycle.
  - LOAD -> SETUP (N+2): PSEL=1, PENABLE=0; PADDR, PWRITE, PSTRB and PPROT valid and held until ACCESS ends.
  - SETUP -> ACCESS (N+3..): PSEL=1, PENABLE=1. The bridge stays in ACCESS while PREADY=0, with no timeout.
- ACCESS with PREADY=1 and PSLVERR=0: next cycle is IDLE with HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. On reads, HRDATA = PRDATA registered at that edge. Minimum total latency is HREADYOUT low for 3 cycles (N+1..N+3).
- ACCESS with PREADY=1 and PSLVERR=1: ERR1 then ERR2, then IDLE.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - HRDATA is unchanged on an error.
- ERR2 is a legal accept cycle only if the master has not cancelled. A new transfer is accepted in ERR2 or IDLE whenever the accept condition holds; in ERR2 the state goes to LOAD.
- PSTRB on writes:
  - byte: 1 << HADDR[1:0]
  - halfword: 4'b0011 << {HADDR[1],1'b0}
  - word: 4'hF
  - PSTRB=0 on reads.
- PPROT: [0] = HPROT[1] (privileged), [1] = 1 (non-secure), [2] = ~HPROT[0] (instruction).
- PSEL never asserts without a completed LOAD. PENABLE is asserted only in ACCESS.

Test Plan:
- Word write HADDR=0x0000_1004, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL at N+2, PENABLE at N+3, PADDR=0x1004, PSTRB=4'hF, PWDATA=0xDEADBEEF, HREADYOUT=1 at N+4, HRESP=0.
- Word read, PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678 -> HREADYOUT low N+1..N+6, HRDATA=0x12345678 with HREADYOUT=1 at N+7.
- Byte write HADDR=0x...3, HPROT=4'b0011 -> PSTRB=4'b1000, PPROT=3'b011.
- Write with PSLVERR=1 on completion -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. A misaligned word at 0x2 -> ERR1 at N+1 with PSEL never asserted.
- Back-to-back SEQ burst of INCR4 words -> four distinct APB transactions with sequential PADDR. HTRANS=BUSY inserted between beats -> no APB activity.
- HRESET asserted during ACCESS -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, all outputs at reset values.

Source files
------------

// File: rtl/ahb3lite_to_apb_bridge.sv
// AHB3-lite slave to APB4 master bridge.
// One APB SETUP/ACCESS per accepted AHB beat; PSLVERR becomes a two-cycle ERROR.
package ahb3lite_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
endpackage

module ahb3lite_to_apb_bridge
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int PADDR_SIZE = 16,
   parameter int DATA_SIZE  = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [DATA_SIZE-1:0]  HWDATA,
   output logic [DATA_SIZE-1:0]  HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [2:0]            PPROT,
   output logic                  PWRITE,
   output logic [3:0]            PSTRB,
   output logic [PADDR_SIZE-1:0] PADDR,
   output logic [DATA_SIZE-1:0]  PWDATA,
   input  logic [DATA_SIZE-1:0]  PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [3:0]            pstrb_q, pstrb_d;
   logic [2:0]            pprot_q, pprot_d;
   logic [DATA_SIZE-1:0]  pwdata_q, pwdata_d;
   logic [DATA_SIZE-1:0]  hrdata_q, hrdata_d;

   logic       req;
   logic       illegal;
   logic [3:0] strb;

   logic unused_ok;
   assign unused_ok = ^{HADDR[HADDR_SIZE-1:PADDR_SIZE],
                        HBURST, HMASTLOCK, HPROT[3:2]};

   assign req = HSEL & HREADY &
                (HTRANS != HTRANS_IDLE) &
                (HTRANS != HTRANS_BUSY);

   assign illegal = (HSIZE > HSIZE_WORD) |
                    ((HSIZE == HSIZE_HWORD) & HADDR[0]) |
                    ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

   always_comb begin
      strb = 4'hF;
      unique case (HSIZE)
         HSIZE_BYTE:  strb = 4'b0001 << HADDR[1:0];
         HSIZE_HWORD: strb = 4'b0011 << {HADDR[1], 1'b0};
         default:     strb = 4'hF;
      endcase
      if (!HWRITE) strb = 4'h0;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pstrb_q  <= 4'h0;
         pprot_q  <= 3'b000;
         pwdata_q <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pstrb_q  <= pstrb_d;
         pprot_q  <= pprot_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pstrb_d   = pstrb_q;
      pprot_d   = pprot_q;
      pwdata_d  = pwdata_q;
      hrdata_d  = hrdata_q;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_ERR2: begin
            if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
            state_d = ST_IDLE;
            if (req) begin
               paddr_d  = HADDR[PADDR_SIZE-1:0];
               pwrite_d = HWRITE;
               pstrb_d  = strb;
               pprot_d  = {~HPROT[0], 1'b1, HPROT[1]};
               state_d  = illegal ? ST_ERR1 : ST_LOAD;
            end
         end
         ST_LOAD: begin
            HREADYOUT = 1'b0;
            pwdata_d  = HWDATA;
            state_d   = ST_SETUP;
         end
         ST_SETUP: begin
            HREADYOUT = 1'b0;
            PSEL      = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            HREADYOUT = 1'b0;
            PSEL      = 1'b1;
            PENABLE   = 1'b1;
            if (PREADY) begin
               if (PSLVERR) begin
                  state_d = ST_ERR1;
               end else begin
                  state_d = ST_IDLE;
                  if (!pwrite_q) hrdata_d = PRDATA;
               end
            end
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign HRDATA = hrdata_q;
   assign PADDR  = paddr_q;
   assign PWRITE = pwrite_q;
   assign PSTRB  = pstrb_q;
   assign PPROT  = pprot_q;
   assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_ahb3lite_to_apb_bridge.sv
// Bench for ahb3lite_to_apb_bridge: directed and random beats
// checked against a cycle-timeline reference model.
module tb_ahb3lite_to_apb_bridge;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic        PSEL;
   logic        PENABLE;
   logic [2:0]  PPROT;
   logic        PWRITE;
   logic [3:0]  PSTRB;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   always #5 HCLK = ~HCLK;

   ahb3lite_to_apb_bridge #(
      .HADDR_SIZE(32),
      .PADDR_SIZE(16),
      .DATA_SIZE (32)
   ) dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HWDATA   (HWDATA),
      .HRDATA   (HRDATA),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HPROT    (HPROT),
      .HTRANS   (HTRANS),
      .HMASTLOCK(HMASTLOCK),
      .HREADY   (HREADY),
      .HREADYOUT(HREADYOUT),
      .HRESP    (HRESP),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PPROT    (PPROT),
      .PWRITE   (PWRITE),
      .PSTRB    (PSTRB),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR)
   );

   int          total = 0;
   int          passed = 0;
   logic [31:0] hrdata_exp = 32'h0;
   logic        resp0_exp = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic rst_chk(input string p);
      chk({p, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
      chk({p, "_hresp"},     32'(HRESP),     32'd0);
      chk({p, "_hrdata"},    HRDATA,         32'd0);
      chk({p, "_psel"},      32'(PSEL),      32'd0);
      chk({p, "_penable"},   32'(PENABLE),   32'd0);
      chk({p, "_pwrite"},    32'(PWRITE),    32'd0);
      chk({p, "_pstrb"},     32'(PSTRB),     32'd0);
      chk({p, "_pprot"},     32'(PPROT),     32'd0);
      chk({p, "_paddr"},     32'(PADDR),     32'd0);
      chk({p, "_pwdata"},    PWDATA,         32'd0);
   endtask

   task automatic idle_chk();
      @(negedge HCLK);
      chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("idle_hresp",     32'(HRESP),     32'(resp0_exp));
      chk("idle_psel",      32'(PSEL),      32'd0);
      chk("idle_penable",   32'(PENABLE),   32'd0);
      chk("idle_hrdata",    HRDATA,         hrdata_exp);
   endtask

   task automatic bus_quiet();
      HSEL    = 1'b0;
      HTRANS  = T_IDLE;
      HREADY  = 1'b1;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
   endtask

   task automatic bus_cycle(input logic sel, input logic rdy,
                            input logic [1:0] trans);
      HSEL   = sel;
      HREADY = rdy;
      HTRANS = trans;
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      HSIZE  = 3'($urandom_range(0, 2));
      idle_chk();
      @(posedge HCLK);
      #1;
      bus_quiet();
      resp0_exp = 1'b0;
   endtask

   // k counts cycles after the address phase; w = PREADY-low ACCESS cycles.
   task automatic xfer(input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] wdata,
                       input int w, input logic err, input logic stop2);
      int          nb, kerr, kdone, last;
      logic        ill, psel_e, pen_e, hro_e, hresp_e;
      logic [3:0]  strb_e;
      logic [2:0]  pprot_e;
      logic [31:0] prd;
      nb      = (size <= 3'd2) ? (1 << size) : 8;
      ill     = (size > 3'd2) || ((addr % nb) != 0);
      strb_e  = wr ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'h0;
      pprot_e = {~prot[0], 1'b1, prot[1]};
      prd     = $urandom;
      if (ill) begin
         kerr  = 1;
         kdone = 3;
      end else if (err) begin
         kerr  = 4 + w;
         kdone = 6 + w;
      end else begin
         kerr  = 0;
         kdone = 4 + w;
      end
      last = (stop2 && kerr != 0) ? kdone - 1 : kdone;

      HSEL      = 1'b1;
      HREADY    = 1'b1;
      HTRANS    = trans;
      HADDR     = addr;
      HWRITE    = wr;
      HSIZE     = size;
      HPROT     = prot;
      HBURST    = 3'($urandom);
      HMASTLOCK = 1'($urandom);
      idle_chk();

      for (int k = 1; k < last; k++) begin
         @(posedge HCLK);
         #1;
         HSEL    = 1'b0;
         HTRANS  = T_IDLE;
         HADDR   = $urandom;
         HWRITE  = 1'($urandom);
         HPROT   = 4'($urandom);
         HWDATA  = (k == 1) ? wdata : $urandom;
         PREADY  = !ill && (k == 3 + w);
         PSLVERR = PREADY ? err : 1'($urandom);
         PRDATA  = (k == 3 + w) ? prd : $urandom;
         @(negedge HCLK);
         psel_e  = !ill && k >= 2 && k <= 3 + w;
         pen_e   = !ill && k >= 3 && k <= 3 + w;
         hro_e   = (kerr != 0) && (k == kerr + 1);
         hresp_e = (kerr != 0) && (k == kerr || k == kerr + 1);
         chk("hreadyout", 32'(HREADYOUT), 32'(hro_e));
         chk("hresp",     32'(HRESP),     32'(hresp_e));
         chk("psel",      32'(PSEL),      32'(psel_e));
         chk("penable",   32'(PENABLE),   32'(pen_e));
         chk("hrdata",    HRDATA,         hrdata_exp);
         if (psel_e) begin
            chk("paddr",  32'(PADDR),  32'(addr[15:0]));
            chk("pwrite", 32'(PWRITE), 32'(wr));
            chk("pstrb",  32'(PSTRB),  32'(strb_e));
            chk("pprot",  32'(PPROT),  32'(pprot_e));
            if (wr) chk("pwdata", PWDATA, wdata);
         end
      end
      @(posedge HCLK);
      #1;
      bus_quiet();
      if (!ill && !err && !wr) hrdata_exp = prd;
      resp0_exp = (last != kdone);
   endtask

   initial begin
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] ad;
      int          nb;

      HRESET    = 1'b1;
      HADDR     = 32'h0;
      HWDATA    = 32'h0;
      HWRITE    = 1'b0;
      HSIZE     = 3'd0;
      HBURST    = 3'd0;
      HPROT     = 4'h0;
      HMASTLOCK = 1'b0;
      PRDATA    = 32'h0;
      bus_quiet();
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      rst_chk("rst");
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      xfer(T_NONSEQ, 32'h0000_1004, 1'b1, 3'd2, 4'h1,
           32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      xfer(T_NONSEQ, 32'h0000_2000, 1'b0, 3'd2, 4'h0,
           32'h0, 3, 1'b0, 1'b0);
      xfer(T_NONSEQ, 32'h0000_0003, 1'b1, 3'd0, 4'b0011,
           32'hA5A5_A5A5, 0, 1'b0, 1'b0);
      xfer(T_NONSEQ, 32'h0000_0042, 1'b1, 3'd1, 4'h1,
           32'h1111_2222, 1, 1'b0, 1'b0);
      xfer(T_NONSEQ, 32'h0000_3008, 1'b1, 3'd2, 4'h1,
           32'hCAFE_F00D, 1, 1'b1, 1'b0);
      xfer(T_NONSEQ, 32'h0000_0002, 1'b1, 3'd2, 4'h1,
           32'h0, 0, 1'b0, 1'b0);
      xfer(T_NONSEQ, 32'h0000_0011, 1'b0, 3'd1, 4'h1,
           32'h0, 0, 1'b0, 1'b1);
      xfer(T_NONSEQ, 32'h0000_0020, 1'b0, 3'd3, 4'h1,
           32'h0, 0, 1'b0, 1'b1);
      xfer(T_NONSEQ, 32'h0000_0024, 1'b0, 3'd2, 4'h3,
           32'h0, 0, 1'b0, 1'b0);

      xfer(T_NONSEQ, 32'h0000_0100, 1'b1, 3'd2, 4'h1,
           32'h0000_0001, 0, 1'b0, 1'b0);
      xfer(T_SEQ, 32'h0000_0104, 1'b1, 3'd2, 4'h1,
           32'h0000_0002, 0, 1'b0, 1'b0);
      bus_cycle(1'b1, 1'b1, T_BUSY);
      xfer(T_SEQ, 32'h0000_0108, 1'b1, 3'd2, 4'h1,
           32'h0000_0003, 0, 1'b0, 1'b0);
      xfer(T_SEQ, 32'h0000_010C, 1'b1, 3'd2, 4'h1,
           32'h0000_0004, 0, 1'b0, 1'b0);
      bus_cycle(1'b1, 1'b0, T_NONSEQ);
      bus_cycle(1'b0, 1'b1, T_NONSEQ);
      bus_cycle(1'b1, 1'b1, T_IDLE);

      for (int i = 0; i < 40; i++) begin
         tr = ($urandom_range(0, 1) == 0) ? T_NONSEQ : T_SEQ;
         sz = ($urandom_range(0, 9) == 0) ?
              3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         nb = (sz <= 3'd2) ? (1 << sz) : 1;
         ad = $urandom;
         ad = ad & ~(32'(nb) - 32'd1);
         if (sz != 3'd0 && $urandom_range(0, 7) == 0) ad = ad | 32'h1;
         xfer(tr, ad, 1'($urandom), sz, 4'($urandom), $urandom,
              $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
              1'($urandom));
         if ($urandom_range(0, 3) == 0)
            bus_cycle(1'($urandom), 1'b1, 2'($urandom_range(0, 1)));
         else if ($urandom_range(0, 3) == 0)
            bus_cycle(1'b1, 1'b0, T_SEQ);
      end
      bus_cycle(1'b0, 1'b1, T_IDLE);

      HSEL   = 1'b1;
      HREADY = 1'b1;
      HTRANS = T_NONSEQ;
      HADDR  = 32'h0000_5550;
      HWRITE = 1'b1;
      HSIZE  = 3'd2;
      HPROT  = 4'h3;
      @(posedge HCLK);
      #1;
      bus_quiet();
      HWDATA = 32'h7777_8888;
      repeat (2) begin
         @(posedge HCLK);
         #1;
      end
      @(negedge HCLK);
      chk("pre_rst_penable", 32'(PENABLE), 32'd1);
      @(posedge HCLK);
      #1;
      HRESET = 1'b1;
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      rst_chk("midrst");
      hrdata_exp = 32'h0;
      resp0_exp  = 1'b0;
      @(posedge HCLK);
      #1;
      bus_cycle(1'b0, 1'b1, T_IDLE);
      xfer(T_NONSEQ, 32'h0000_0200, 1'b0, 3'd2, 4'h0,
           32'h0, 0, 1'b0, 1'b0);
      bus_cycle(1'b0, 1'b1, T_IDLE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
